// File: rtl/msg_tracker_pkg.sv
// Shared constants for the multi-channel message framing monitor.
// Channel state encodings and framing error codes used by msg_tracker and msg_chan_fsm.
package msg_tracker_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ORPHAN  = 2'b01;
    localparam logic [1:0] ERR_LONG    = 2'b10;
    localparam logic [1:0] ERR_RESTART = 2'b11;

    // Index width that never collapses to zero for a single channel.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/msg_chan_fsm.sv
// One channel's IDLE/SEND/DROP framing tracker with a beat counter.
// Emits combinational event strobes for the beat it is handed; the top registers them.
module msg_chan_fsm
    import msg_tracker_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             beat,
    input  logic             head,
    input  logic             tail,
    output logic             in_send,
    output logic             ev_start,
    output logic             ev_done,
    output logic             ev_err,
    output logic [1:0]       ev_code,
    output logic [LEN_W-1:0] ev_len
);

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [LEN_W-1:0] cnt_r;
    logic [LEN_W-1:0] cnt_nxt_s;
    logic [LEN_W-1:0] cnt_inc_s;
    logic             send_r;

    // Next-state, counter and event decode for the beat presented this cycle.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        ev_start    = 1'b0;
        ev_done     = 1'b0;
        ev_err      = 1'b0;
        ev_code     = ERR_NONE;
        ev_len      = {LEN_W{1'b0}};
        cnt_inc_s   = cnt_r + LEN_W'(1);
        if (beat) begin
            case (state_r)
                IDLE, DROP: begin
                    // A head opens a message from IDLE and from DROP alike.
                    if (head) begin
                        ev_done     = tail;
                        ev_start    = ~tail;
                        ev_len      = tail ? LEN_W'(1) : {LEN_W{1'b0}};
                        state_nxt_s = tail ? IDLE : SEND;
                        cnt_nxt_s   = tail ? {LEN_W{1'b0}} : LEN_W'(1);
                    end else if (state_r == IDLE) begin
                        ev_err  = 1'b1;
                        ev_code = ERR_ORPHAN;
                    end else begin
                        state_nxt_s = tail ? IDLE : DROP;
                    end
                end
                SEND: begin
                    if (head) begin
                        ev_err      = 1'b1;
                        ev_code     = ERR_RESTART;
                        ev_done     = tail;
                        ev_start    = ~tail;
                        ev_len      = tail ? LEN_W'(1) : {LEN_W{1'b0}};
                        state_nxt_s = tail ? IDLE : SEND;
                        cnt_nxt_s   = tail ? {LEN_W{1'b0}} : LEN_W'(1);
                    end else if (tail) begin
                        ev_done     = 1'b1;
                        ev_len      = cnt_inc_s;
                        state_nxt_s = IDLE;
                        cnt_nxt_s   = {LEN_W{1'b0}};
                    end else if (cnt_inc_s == LEN_W'(MAX_LEN)) begin
                        ev_err      = 1'b1;
                        ev_code     = ERR_LONG;
                        state_nxt_s = DROP;
                        cnt_nxt_s   = {LEN_W{1'b0}};
                    end else begin
                        cnt_nxt_s = cnt_inc_s;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = {LEN_W{1'b0}};
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Channel state, beat counter and registered in-message flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            cnt_r   <= {LEN_W{1'b0}};
            send_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            send_r  <= (state_nxt_s == SEND);
        end
    end

    assign in_send = send_r;

endmodule

// File: rtl/msg_tracker.sv
// Multi-channel message framing monitor: one msg_chan_fsm per channel, with the
// single active channel's events registered onto shared pulse/status outputs.
module msg_tracker
    import msg_tracker_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int MAX_LEN = 16,
    localparam int CH_W   = idx_width(NUM_CH),
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              valid,
    input  logic              head,
    input  logic              tail,
    input  logic [CH_W-1:0]   chan,
    output logic [NUM_CH-1:0] msg_ip,
    output logic              msg_start,
    output logic              msg_done,
    output logic [CH_W-1:0]   done_chan,
    output logic [LEN_W-1:0]  done_len,
    output logic              err,
    output logic [1:0]        err_code
);

    logic [NUM_CH-1:0] beat_s;
    logic [NUM_CH-1:0] in_send_s;
    logic [NUM_CH-1:0] ev_start_s;
    logic [NUM_CH-1:0] ev_done_s;
    logic [NUM_CH-1:0] ev_err_s;
    logic [1:0]        ev_code_s [NUM_CH];
    logic [LEN_W-1:0]  ev_len_s  [NUM_CH];

    logic              sel_start_s;
    logic              sel_done_s;
    logic              sel_err_s;
    logic [1:0]        sel_code_s;
    logic [LEN_W-1:0]  sel_len_s;
    logic [CH_W-1:0]   sel_chan_s;

    logic              msg_start_r;
    logic              msg_done_r;
    logic              err_r;
    logic [1:0]        err_code_r;
    logic [LEN_W-1:0]  done_len_r;
    logic [CH_W-1:0]   done_chan_r;

    // Out-of-range channel numbers never match a gate, so they are ignored outright.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign beat_s[c] = valid && (chan == CH_W'(c));

        msg_chan_fsm #(
            .MAX_LEN (MAX_LEN),
            .LEN_W   (LEN_W)
        ) u_chan (
            .clock    (clock),
            .reset_n  (reset_n),
            .beat     (beat_s[c]),
            .head     (head),
            .tail     (tail),
            .in_send  (in_send_s[c]),
            .ev_start (ev_start_s[c]),
            .ev_done  (ev_done_s[c]),
            .ev_err   (ev_err_s[c]),
            .ev_code  (ev_code_s[c]),
            .ev_len   (ev_len_s[c])
        );
    end

    // OR-merge channel events; at most one channel sees a beat per cycle.
    always_comb begin
        sel_start_s = 1'b0;
        sel_done_s  = 1'b0;
        sel_err_s   = 1'b0;
        sel_code_s  = ERR_NONE;
        sel_len_s   = {LEN_W{1'b0}};
        sel_chan_s  = {CH_W{1'b0}};
        for (int c = 0; c < NUM_CH; c++) begin
            sel_start_s = sel_start_s | ev_start_s[c];
            sel_done_s  = sel_done_s  | ev_done_s[c];
            sel_err_s   = sel_err_s   | ev_err_s[c];
            sel_code_s  = sel_code_s  | ev_code_s[c];
            sel_len_s   = sel_len_s   | ev_len_s[c];
            sel_chan_s  = sel_chan_s  | (beat_s[c] ? CH_W'(c) : {CH_W{1'b0}});
        end
    end

    // Event registers: pulses last one cycle, status fields hold until their next event.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            msg_start_r <= 1'b0;
            msg_done_r  <= 1'b0;
            err_r       <= 1'b0;
            err_code_r  <= ERR_NONE;
            done_len_r  <= {LEN_W{1'b0}};
            done_chan_r <= {CH_W{1'b0}};
        end else begin
            msg_start_r <= sel_start_s;
            msg_done_r  <= sel_done_s;
            err_r       <= sel_err_s;
            if (sel_start_s || sel_done_s || sel_err_s) begin
                done_chan_r <= sel_chan_s;
            end else begin
                done_chan_r <= done_chan_r;
            end
            if (sel_done_s) begin
                done_len_r <= sel_len_s;
            end else begin
                done_len_r <= done_len_r;
            end
            if (sel_err_s) begin
                err_code_r <= sel_code_s;
            end else begin
                err_code_r <= err_code_r;
            end
        end
    end

    assign msg_ip    = in_send_s;
    assign msg_start = msg_start_r;
    assign msg_done  = msg_done_r;
    assign err       = err_r;
    assign err_code  = err_code_r;
    assign done_len  = done_len_r;
    assign done_chan = done_chan_r;

endmodule
